seg_scan8: RTL and testbench

SEG_SCAN8 -- requirements
Module: seg_scan8

---
 rtl/seg_scan8_pkg.sv | 13 +
 rtl/seg7_dec.sv | 21 ++
 rtl/seg_defs.vh | 15 +
 rtl/seg_scan8.sv | 69 ++++++
 tb/tb_seg_scan8.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/seg_scan8_pkg.sv
// Shared types and constants for the 8-digit history scanner.
package seg_scan8_pkg;
    `include "seg_defs.vh"

    localparam int PRE_W  = 20;
    localparam int DIGITS = 8;

    typedef logic [DIGITS-1:0][2:0] hist_t;

    function automatic logic [7:0] an_sel(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction
endpackage

// File: rtl/seg7_dec.sv
// 3-bit value to active-low seven-segment pattern.
module seg7_dec
    import seg_scan8_pkg::*;
(
    input  logic [2:0] q,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        unique case (q)
            3'd0: seg = SEG_D0;
            3'd1: seg = SEG_D1;
            3'd2: seg = SEG_D2;
            3'd3: seg = SEG_D3;
            3'd4: seg = SEG_D4;
            3'd5: seg = SEG_D5;
            3'd6: seg = SEG_D6;
            3'd7: seg = SEG_D7;
        endcase
    end
endmodule

// File: rtl/seg_defs.vh
// Seven-segment encodings and idle/blank constants, active-low {g,f,e,d,c,b,a}.
// Shared by the scanner and the counter's own display decoder.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH
localparam logic [6:0] SEG_D0    = 7'b1000000;
localparam logic [6:0] SEG_D1    = 7'b1111001;
localparam logic [6:0] SEG_D2    = 7'b0100100;
localparam logic [6:0] SEG_D3    = 7'b0110000;
localparam logic [6:0] SEG_D4    = 7'b0011001;
localparam logic [6:0] SEG_D5    = 7'b0010010;
localparam logic [6:0] SEG_D6    = 7'b0000010;
localparam logic [6:0] SEG_D7    = 7'b1111000;
localparam logic [6:0] SEG_BLANK = 7'b1111111;
localparam logic [7:0] AN_IDLE   = 8'hFF;
`endif

// File: rtl/seg_scan8.sv
// Scans an 8-deep history of a 3-bit counter across eight multiplexed digits.
module seg_scan8
    import seg_scan8_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [2:0] iQ,
    output logic [6:0] oSeg,
    output logic [7:0] oAn,
    output logic [3:0] oFill
);
    hist_t            hist;
    hist_t            hist_nxt;
    logic [3:0]       fill;
    logic [3:0]       fill_nxt;
    logic             primed;
    logic [2:0]       q_prev;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [PRE_W-1:0] pre;
    logic             wrap;
    logic             load;
    logic [6:0]       dec_seg;

    assign load    = !primed || (iQ != q_prev);
    assign wrap    = (pre == PRE_W'(SCAN_DIV - 1));
    assign idx_nxt = wrap ? idx + 3'd1 : idx;
    assign oFill   = fill;

    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        if (load) begin
            hist_nxt = {hist[DIGITS-2:0], iQ};
            if (fill != 4'd8)
                fill_nxt = fill + 4'd1;
        end
    end

    // Decode the post-edge digit so a load and an advance land together.
    seg7_dec u_dec (
        .q   (hist_nxt[idx_nxt]),
        .seg (dec_seg)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            fill   <= '0;
            primed <= 1'b0;
            q_prev <= '0;
            pre    <= '0;
            idx    <= '0;
            oAn    <= AN_IDLE;
            oSeg   <= SEG_BLANK;
        end else begin
            hist   <= hist_nxt;
            fill   <= fill_nxt;
            primed <= 1'b1;
            q_prev <= iQ;
            pre    <= wrap ? '0 : pre + PRE_W'(1);
            idx    <= idx_nxt;
            oAn    <= an_sel(idx_nxt);
            oSeg   <= ({1'b0, idx_nxt} < fill_nxt) ? dec_seg : SEG_BLANK;
        end
    end
endmodule

// File: tb/tb_seg_scan8.sv
// Scoreboard bench for seg_scan8 with SCAN_DIV=4 and a 20 ns clock.
module tb_seg_scan8;
    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] iQ = 3'd3;
    logic [6:0] oSeg;
    logic [7:0] oAn;
    logic [3:0] oFill;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic [3:0] fill;
    } exp_t;

    exp_t sb[$];

    logic [6:0] enc [8] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    seg_scan8 #(.SCAN_DIV(4)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .iQ    (iQ),
        .oSeg  (oSeg),
        .oAn   (oAn),
        .oFill (oFill)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference model: history, fill, prescaler and digit index.
    initial begin
        logic [2:0] mh [8];
        logic [3:0] mf;
        logic       mp;
        logic [2:0] mq;
        int         mpre;
        int         midx;
        exp_t       e;
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) mh[k] = 3'd0;
                mf = 0; mp = 0; mq = 0; mpre = 0; midx = 0;
                sb.delete();
            end else begin
                if (!mp || iQ != mq) begin
                    for (int k = 7; k > 0; k--) mh[k] = mh[k-1];
                    mh[0] = iQ;
                    if (mf < 8) mf = mf + 1;
                end
                mp = 1;
                mq = iQ;
                mpre = mpre + 1;
                if (mpre == 4) begin
                    mpre = 0;
                    midx = (midx + 1) % 8;
                end
                e.an = 8'hFF;
                e.an[midx] = 1'b0;
                e.seg = (midx < int'(mf)) ? enc[mh[midx]] : 7'h7F;
                e.fill = mf;
                sb.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                chk("an", 32'(oAn), 32'(e.an));
                chk("seg", 32'(oSeg), 32'(e.seg));
                chk("fill", 32'(oFill), 32'(e.fill));
            end
        end
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_an", 32'(oAn), 32'hFF);
        chk("rst_seg", 32'(oSeg), 32'h7F);
        chk("rst_fill", 32'(oFill), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_fill", 32'(oFill), 32'd1);
        chk("first_an", 32'(oAn), 32'hFE);
        chk("first_seg", 32'(oSeg), 32'b0110000);
        repeat (40) @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            iQ = 3'(i);
            repeat (3) @(negedge CLK);
        end
        repeat (40) @(negedge CLK);
        chk("sat_fill", 32'(oFill), 32'd8);

        iQ = 3'd0;
        repeat (40) @(negedge CLK);
        chk("wrap_fill", 32'(oFill), 32'd8);

        iQ = 3'd5;
        repeat (100) @(negedge CLK);
        chk("hold_fill", 32'(oFill), 32'd8);

        for (int i = 0; i < 48; i++) begin
            iQ = 3'($urandom_range(0, 7));
            @(negedge CLK);
        end

        @(posedge CLK);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_an", 32'(oAn), 32'hFF);
        chk("mid_seg", 32'(oSeg), 32'h7F);
        chk("mid_fill", 32'(oFill), 32'd0);
        #4 rst_n = 1'b1;
        iQ = 3'd6;
        @(posedge CLK);
        #1;
        chk("refill", 32'(oFill), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i % 2 == 0) iQ = iQ + 3'd1;
        end
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
